issue_comparator: RTL and testbench



---
 rtl/issue_comparator_pkg.sv | 24 ++
 rtl/issue_comparator_if.sv | 19 +
 rtl/issue_comparator_operand_snoop.sv | 25 ++
 rtl/issue_comparator.sv | 105 ++++++++++
 tb/tb_issue_comparator.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_comparator_pkg.sv
// issue_comparator_pkg: shared decode types and issue-stage state encoding.
package issue_comparator_pkg;
    localparam int DEF_XLEN      = 32;
    localparam int DEF_TAG_W     = 6;
    localparam int DEF_CDB_COUNT = 2;
    typedef enum logic [3:0] {
        I_NOP, I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL,
        I_MUL, I_LW, I_SW, I_BEQ, I_BNE, I_JAL
    } instr_name_e;
    typedef enum logic [2:0] {T_NONE, T_ALU, T_MUL, T_MEM, T_BRANCH} instr_type_e;
    typedef struct packed {
        logic [DEF_TAG_W-1:0] rs_1;
        logic [DEF_TAG_W-1:0] rs_2;
        logic [DEF_TAG_W-1:0] rd;
        logic [DEF_TAG_W-1:0] rn;
    } registers_t;
    typedef struct packed {
        logic uses_imm;
        logic is_load;
        logic is_store;
        logic is_branch;
    } flag_vector_t;
    typedef enum logic {ISSUE_EMPTY, ISSUE_HOLD} issue_state_e;
endpackage

// File: rtl/issue_comparator_if.sv
// issue_comparator_if: registered issue bundle towards reservation stations and ROB.
interface issue_comparator_if import issue_comparator_pkg::*; #(
    parameter int XLEN = DEF_XLEN
);
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] immediate;
    instr_name_e     instr_name;
    instr_type_e     instr_type;
    registers_t      regs;
    flag_vector_t    flags;
    logic [XLEN-1:0] data_1;
    logic [XLEN-1:0] data_2;
    logic            valid_1;
    logic            valid_2;
    modport master (output address, immediate, instr_name, instr_type, regs, flags,
                    data_1, data_2, valid_1, valid_2);
    modport slave  (input  address, immediate, instr_name, instr_type, regs, flags,
                    data_1, data_2, valid_1, valid_2);
endinterface

// File: rtl/issue_comparator_operand_snoop.sv
// issue_comparator_operand_snoop: match one source tag against all CDB ports, lowest port wins.
module issue_comparator_operand_snoop #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 6,
    parameter int CDB_COUNT = 2
) (
    input  logic [TAG_W-1:0]                 tag,
    input  logic [CDB_COUNT-1:0]             cdb_valid,
    input  logic [CDB_COUNT-1:0][TAG_W-1:0]  cdb_tag,
    input  logic [CDB_COUNT-1:0][XLEN-1:0]   cdb_data,
    output logic                             hit,
    output logic [XLEN-1:0]                  data
);
    // scanning downwards lets the lowest-index hit be applied last
    always_comb begin
        hit = 1'b0;
        data = '0;
        for (int k = CDB_COUNT - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k] == tag) begin
                hit = 1'b1;
                data = cdb_data[k];
            end
        end
    end
endmodule

// File: rtl/issue_comparator.sv
// issue_comparator: one-entry issue stage resolving operands from RF/CDB and snooping while held.
module issue_comparator import issue_comparator_pkg::*; #(
    parameter int XLEN      = DEF_XLEN,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int CDB_COUNT = DEF_CDB_COUNT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [XLEN-1:0]                 in_address,
    input  logic [XLEN-1:0]                 in_immediate,
    input  instr_name_e                     in_instr_name,
    input  instr_type_e                     in_instr_type,
    input  registers_t                      in_regs,
    input  flag_vector_t                    in_flags,
    input  logic [XLEN-1:0]                 rf_data_1,
    input  logic [XLEN-1:0]                 rf_data_2,
    input  logic                            rf_valid_1,
    input  logic                            rf_valid_2,
    input  logic [CDB_COUNT-1:0]            cdb_valid,
    input  logic [CDB_COUNT-1:0][TAG_W-1:0] cdb_tag,
    input  logic [CDB_COUNT-1:0][XLEN-1:0]  cdb_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    issue_comparator_if.master              issue
);
    issue_state_e    state, next_state;
    logic            cap, hit_1, hit_2, cdb_dup;
    logic [TAG_W-1:0] tag_1, tag_2;
    logic [XLEN-1:0] snp_1, snp_2;

    // one snooper per source: incoming tags on capture, held tags otherwise
    always_comb begin
        in_ready = !flush && (state == ISSUE_EMPTY || out_ready);
        cap = in_valid && in_ready;
        tag_1 = cap ? in_regs.rs_1 : issue.regs.rs_1;
        tag_2 = cap ? in_regs.rs_2 : issue.regs.rs_2;
    end

    issue_comparator_operand_snoop #(.XLEN(XLEN), .TAG_W(TAG_W), .CDB_COUNT(CDB_COUNT)) u_snoop_1 (
        .tag(tag_1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .hit(hit_1), .data(snp_1)
    );
    issue_comparator_operand_snoop #(.XLEN(XLEN), .TAG_W(TAG_W), .CDB_COUNT(CDB_COUNT)) u_snoop_2 (
        .tag(tag_2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .hit(hit_2), .data(snp_2)
    );

    always_ff @(posedge clk) state <= reset ? ISSUE_EMPTY : next_state;

    always_comb next_state = flush ? ISSUE_EMPTY : cap ? ISSUE_HOLD :
                             (state == ISSUE_HOLD && out_ready) ? ISSUE_EMPTY : state;

    always_comb out_valid = state == ISSUE_HOLD;

    always_ff @(posedge clk) begin
        if (reset) begin
            issue.address    <= '0;
            issue.immediate  <= '0;
            issue.instr_name <= I_NOP;
            issue.instr_type <= T_NONE;
            issue.regs       <= '0;
            issue.flags      <= '0;
            issue.data_1     <= '0;
            issue.data_2     <= '0;
            issue.valid_1    <= 1'b0;
            issue.valid_2    <= 1'b0;
        end else if (cap) begin
            issue.address    <= in_address;
            issue.immediate  <= in_immediate;
            issue.instr_name <= in_instr_name;
            issue.instr_type <= in_instr_type;
            issue.regs       <= in_regs;
            issue.flags      <= in_flags;
            issue.valid_1    <= ~|in_regs.rs_1 || rf_valid_1 || hit_1;
            issue.valid_2    <= ~|in_regs.rs_2 || rf_valid_2 || hit_2;
            issue.data_1     <= ~|in_regs.rs_1 ? '0 : rf_valid_1 ? rf_data_1 : hit_1 ? snp_1 : issue.data_1;
            issue.data_2     <= ~|in_regs.rs_2 ? '0 : rf_valid_2 ? rf_data_2 : hit_2 ? snp_2 : issue.data_2;
        end else if (state == ISSUE_HOLD) begin
            if (!issue.valid_1 && hit_1) begin
                issue.valid_1 <= 1'b1;
                issue.data_1  <= snp_1;
            end
            if (!issue.valid_2 && hit_2) begin
                issue.valid_2 <= 1'b1;
                issue.data_2  <= snp_2;
            end
        end
    end

    always_comb begin
        cdb_dup = 1'b0;
        for (int i = 0; i < CDB_COUNT; i++)
            for (int j = i + 1; j < CDB_COUNT; j++)
                cdb_dup = cdb_dup || (cdb_valid[i] && cdb_valid[j] && cdb_tag[i] == cdb_tag[j]);
    end

    a_cdb_unique: assert property (@(posedge clk) disable iff (reset) !cdb_dup);
    // a flushed upstream is free to change its offer
    a_in_stable: assert property (@(posedge clk) disable iff (reset)
        in_valid && !in_ready && !flush |=> in_valid &&
        $stable({in_address, in_immediate, in_instr_name, in_instr_type, in_regs, in_flags}));
endmodule

// File: tb/tb_issue_comparator.sv
// tb_issue_comparator: scoreboard bench with a rule-level operand model and random traffic.
module tb_issue_comparator;
    import issue_comparator_pkg::*;

    typedef struct {
        logic [31:0]  address;
        logic [31:0]  immediate;
        instr_name_e  name;
        instr_type_e  typ;
        registers_t   regs;
        flag_vector_t flags;
        logic         v1, v2;
        logic [31:0]  d1, d2;
    } rec_t;

    logic clk = 0, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic rf_valid_1, rf_valid_2;
    logic [31:0] in_address, in_immediate, rf_data_1, rf_data_2;
    instr_name_e in_instr_name;
    instr_type_e in_instr_type;
    registers_t in_regs;
    flag_vector_t in_flags;
    logic [1:0] cdb_valid;
    logic [1:0][5:0] cdb_tag;
    logic [1:0][31:0] cdb_data;

    rec_t q[$];
    logic full = 0, took = 0;
    int n_cmp = 0, n_bad = 0;

    issue_comparator_if #(.XLEN(32)) issue();

    issue_comparator dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_address(in_address), .in_immediate(in_immediate), .in_instr_name(in_instr_name),
        .in_instr_type(in_instr_type), .in_regs(in_regs), .in_flags(in_flags),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2), .rf_valid_1(rf_valid_1), .rf_valid_2(rf_valid_2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .issue(issue.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void cdb_look(input logic [5:0] rs, output logic h, output logic [31:0] d);
        h = 0;
        d = '0;
        for (int k = 0; k < 2; k++)
            if (!h && cdb_valid[k] && cdb_tag[k] == rs) begin
                h = 1;
                d = cdb_data[k];
            end
    endfunction

    function automatic void resolve(input logic [5:0] rs, input logic fv, input logic [31:0] fd,
                                    output logic v, output logic [31:0] d);
        logic h;
        logic [31:0] cd;
        cdb_look(rs, h, cd);
        if (rs == 0) begin v = 1; d = 0; end
        else if (fv) begin v = 1; d = fd; end
        else begin v = h; d = cd; end
    endfunction

    // reference: occupancy bit plus queued records, updated by the spec rules each edge
    always @(posedge clk) begin : model
        rec_t r;
        logic h, cap;
        logic [31:0] d;
        took = 0;
        if (reset || flush) begin
            full = 0;
            q.delete();
        end else begin
            cap = in_valid && (!full || out_ready);
            if (q.size() > 0) begin
                r = q[0];
                if (!r.v1) begin cdb_look(r.regs.rs_1, h, d); if (h) begin r.v1 = 1; r.d1 = d; end end
                if (!r.v2) begin cdb_look(r.regs.rs_2, h, d); if (h) begin r.v2 = 1; r.d2 = d; end end
                q[0] = r;
            end
            if (cap) begin
                r.address = in_address;
                r.immediate = in_immediate;
                r.name = in_instr_name;
                r.typ = in_instr_type;
                r.regs = in_regs;
                r.flags = in_flags;
                resolve(in_regs.rs_1, rf_valid_1, rf_data_1, r.v1, r.d1);
                resolve(in_regs.rs_2, rf_valid_2, rf_data_2, r.v2, r.d2);
                q.push_back(r);
                full = 1;
                took = 1;
            end else if (full && out_ready) full = 0;
        end
    end

    always @(negedge clk) begin : mon
        rec_t r;
        if (!reset) begin
            chk("out_valid", out_valid, full);
            chk("in_ready", in_ready, !flush && (!full || out_ready));
            if (out_valid && out_ready) begin
                chk("sb_nonempty", q.size() != 0, 1);
                if (q.size() > 0) begin
                    r = q.pop_front();
                    chk("address", issue.address, r.address);
                    chk("immediate", issue.immediate, r.immediate);
                    chk("instr_name", issue.instr_name, r.name);
                    chk("instr_type", issue.instr_type, r.typ);
                    chk("regs", issue.regs, r.regs);
                    chk("flags", issue.flags, r.flags);
                    chk("valid_1", issue.valid_1, r.v1);
                    chk("valid_2", issue.valid_2, r.v2);
                    if (r.v1) chk("data_1", issue.data_1, r.d1);
                    if (r.v2) chk("data_2", issue.data_2, r.d2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_instr();
        in_address = $urandom;
        in_immediate = $urandom;
        in_instr_name = instr_name_e'($urandom_range(0, 13));
        in_instr_type = instr_type_e'($urandom_range(0, 4));
        in_regs.rs_1 = 6'($urandom_range(0, 7));
        in_regs.rs_2 = 6'($urandom_range(0, 7));
        in_regs.rd = 6'($urandom);
        in_regs.rn = 6'($urandom);
        in_flags = 4'($urandom);
    endtask

    task automatic set_src(input logic [5:0] r1, input logic [5:0] r2, input logic v1, input logic v2,
                           input logic [31:0] d1, input logic [31:0] d2);
        in_regs.rs_1 = r1;
        in_regs.rs_2 = r2;
        rf_valid_1 = v1;
        rf_valid_2 = v2;
        rf_data_1 = d1;
        rf_data_2 = d2;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ovalid"}, out_valid, 0);
        chk({nm, "_fields"}, {issue.address, issue.immediate, issue.instr_name, issue.instr_type,
                              issue.regs, issue.flags} == '0, 1);
        chk({nm, "_data"}, {issue.data_1, issue.data_2, issue.valid_1, issue.valid_2} == '0, 1);
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; out_ready = 0; cdb_valid = 0;
        cdb_tag = '0; cdb_data = '0;
        rand_instr();
        set_src(0, 0, 0, 0, 0, 0);
        tick(); tick();
        check_zero("reset");
        reset = 0;
        // both sources from the register file
        rand_instr();
        set_src(5, 6, 1, 1, 32'h11, 32'h22);
        in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        chk("t1_ovalid", out_valid, 1);
        chk("t1_data_1", issue.data_1, 32'h11);
        chk("t1_data_2", issue.data_2, 32'h22);
        chk("t1_valids", {issue.valid_1, issue.valid_2}, 2'b11);
        chk("t1_in_ready", in_ready, 1);
        tick();
        // wakeup from CDB port 1 while held
        rand_instr();
        set_src(7, 0, 0, 0, 32'h99, 0);
        in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        chk("t2_wait_valid_1", issue.valid_1, 0);
        tick();
        cdb_valid = 2'b10; cdb_tag[1] = 7; cdb_data[1] = 32'hDEAD;
        tick();
        cdb_valid = 0;
        chk("t2_valid_1", issue.valid_1, 1);
        chk("t2_data_1", issue.data_1, 32'hDEAD);
        out_ready = 1;
        tick();
        // same-cycle CDB bypass on source 2
        rand_instr();
        set_src(3, 9, 1, 0, 32'h33, 0);
        cdb_valid = 2'b01; cdb_tag[0] = 9; cdb_data[0] = 32'h42;
        in_valid = 1;
        tick();
        chk("t3_valid_2", issue.valid_2, 1);
        chk("t3_data_2", issue.data_2, 32'h42);
        // x0 ignores a CDB broadcast of tag 0
        rand_instr();
        set_src(0, 0, 0, 0, 32'h55, 0);
        cdb_valid = 2'b01; cdb_tag[0] = 0; cdb_data[0] = 32'hFFFF;
        tick();
        cdb_valid = 0;
        chk("t4_data_1", issue.data_1, 0);
        chk("t4_valid_1", issue.valid_1, 1);
        // stream with one backpressure cycle
        rand_instr();
        in_valid = 1;
        begin
            int sent = 0;
            for (int i = 0; i < 6; i++) begin
                out_ready = i != 1;
                in_valid = sent < 4;
                tick();
                if (took) begin sent++; rand_instr(); end
            end
        end
        in_valid = 0; out_ready = 1;
        tick();
        // flush over a held instruction with a simultaneous offer
        rand_instr();
        in_valid = 1; out_ready = 0;
        tick();
        rand_instr();
        flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("t6_flush_ovalid", out_valid, 0);
        tick();
        chk("t6_flush_empty", out_valid, 0);
        rand_instr();
        set_src(4, 5, 1, 1, 32'hA, 32'hB);
        in_valid = 1;
        tick();
        rand_instr();
        reset = 1;
        tick();
        check_zero("t6_reset");
        reset = 0; in_valid = 0;
        tick();
        // random traffic
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || took || flush || reset) begin
                rand_instr();
                in_valid = $urandom_range(0, 3) != 0;
            end
            rf_valid_1 = $urandom_range(0, 1);
            rf_valid_2 = $urandom_range(0, 1);
            rf_data_1 = $urandom;
            rf_data_2 = $urandom;
            cdb_valid = 2'($urandom);
            cdb_tag[0] = 6'($urandom_range(0, 7));
            cdb_tag[1] = 6'($urandom_range(0, 7));
            cdb_data[0] = $urandom;
            cdb_data[1] = $urandom;
            if (cdb_valid == 2'b11 && cdb_tag[0] == cdb_tag[1]) cdb_valid[1] = 0;
            out_ready = $urandom_range(0, 4) < 3;
            flush = $urandom_range(0, 24) == 0;
            reset = $urandom_range(0, 99) == 0;
            tick();
        end
        reset = 0; flush = 0; in_valid = 0; cdb_valid = 0; out_ready = 1;
        tick(); tick(); tick();
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
